// File: rtl/core_mc.sv
// Multi-cycle RV32I/RV64I integer core with valid/ready fetch and data ports and an EBREAK halt.
// Latency: ALU/branch/jump 3 cycles (IF_REQ, IF_WAIT, EX); load/store 5 cycles, plus any stall/response wait.
// Backpressure: request valid and fields stay stable until ready is sampled high; one outstanding request per port.
// Ports: clk/rst (async, active-high); imem_req_valid/ready, imem_addr, imem_resp_valid, imem_rdata (fetch);
//        dmem_req_valid/ready, dmem_wen, dmem_addr, dmem_wdata, dmem_resp_valid, dmem_rdata (data);
//        pc_out (architectural pc), retire (one pulse per commit), halted (set by EBREAK).
module core_mc #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h80000000)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_wen,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_resp_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] pc_out,
    output logic            retire,
    output logic            halted
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL   = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG   = 7'b0110011,
                           OP_IMM32 = 7'b0011011, OP_REG32 = 7'b0111011;

    typedef enum logic [2:0] {IF_REQ, IF_WAIT, EX, MEM_REQ, MEM_WAIT, HALT} state_t;
    state_t state, state_n;

    logic [XLEN-1:0] pc, pc_plus4, pc_next, ex_pc_next;
    logic [31:0]     ir;
    logic [XLEN-1:0] rf [32];

    // Decode fields are taken from ir only, so the fetch bus may change freely after the handshake.
    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_val, rs2_val;
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign imm_i  = XLEN'($signed(ir[31:20]));
    assign imm_s  = XLEN'($signed({ir[31:25], ir[11:7]}));
    assign imm_b  = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({ir[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
    assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];

    function automatic logic [XLEN-1:0] alu_x(input logic [2:0] f3, input logic alt,
                                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        logic [SHW-1:0]  sh;
        sh = b[SHW-1:0];
        case (f3)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << sh;
            3'b010:  r = XLEN'($signed(a) < $signed(b));
            3'b011:  r = XLEN'(a < b);
            3'b100:  r = a ^ b;
            3'b101:  if (alt) r = $signed(a) >>> sh; else r = a >> sh;
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // 32-bit "W" operations: compute on the low word, then sign-extend the result.
    function automatic logic [XLEN-1:0] alu_w(input logic [2:0] f3, input logic alt,
                                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [31:0] r;
        case (f3)
            3'b001:  r = a[31:0] << b[4:0];
            3'b101:  if (alt) r = $signed(a[31:0]) >>> b[4:0]; else r = a[31:0] >> b[4:0];
            default: r = alt ? (a[31:0] - b[31:0]) : (a[31:0] + b[31:0]);
        endcase
        return XLEN'($signed(r));
    endfunction

    function automatic logic br_cond(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Control: select ALU operands/function and classify the instruction.
    logic [XLEN-1:0] alu_a, alu_b, alu_res, wb_val, rf_wd;
    logic [2:0]      alu_f3;
    logic            alu_alt, alu_word, reg_wen, is_load, is_store, is_branch, is_jal, is_jalr;
    logic            is_ebreak, taken, rf_we;
    always_comb begin
        alu_a = rs1_val; alu_b = imm_i; alu_f3 = 3'b000; alu_alt = 1'b0; alu_word = 1'b0;
        reg_wen = 1'b0; is_load = 1'b0; is_store = 1'b0; is_branch = 1'b0;
        is_jal = 1'b0; is_jalr = 1'b0;
        case (opcode)
            OP_LUI:    begin alu_a = '0; alu_b = imm_u; reg_wen = 1'b1; end
            OP_AUIPC:  begin alu_a = pc; alu_b = imm_u; reg_wen = 1'b1; end
            OP_JAL:    begin is_jal = 1'b1; reg_wen = 1'b1; end
            OP_JALR:   begin is_jalr = 1'b1; reg_wen = 1'b1; end
            OP_BRANCH: is_branch = 1'b1;
            OP_LOAD:   is_load = 1'b1;
            OP_STORE:  begin is_store = 1'b1; alu_b = imm_s; end
            OP_IMM:    begin alu_f3 = funct3; alu_alt = (funct3 == 3'b101) & ir[30]; reg_wen = 1'b1; end
            OP_REG:    begin alu_b = rs2_val; alu_f3 = funct3; alu_alt = ir[30]; reg_wen = 1'b1; end
            OP_IMM32:  if (XLEN == 64) begin
                           alu_f3 = funct3; alu_alt = (funct3 == 3'b101) & ir[30];
                           alu_word = 1'b1; reg_wen = 1'b1;
                       end
            OP_REG32:  if (XLEN == 64) begin
                           alu_b = rs2_val; alu_f3 = funct3; alu_alt = ir[30];
                           alu_word = 1'b1; reg_wen = 1'b1;
                       end
            default: ;
        endcase
    end

    assign alu_res   = alu_word ? alu_w(alu_f3, alu_alt, alu_a, alu_b) : alu_x(alu_f3, alu_alt, alu_a, alu_b);
    assign is_ebreak = (ir == 32'h00100073);
    assign taken     = is_branch && br_cond(funct3, rs1_val, rs2_val);
    assign pc_plus4  = pc + XLEN'(4);
    assign wb_val    = (is_jal || is_jalr) ? pc_plus4 : alu_res;

    always_comb begin
        if (is_ebreak)    ex_pc_next = pc;
        else if (is_jalr) ex_pc_next = {alu_res[XLEN-1:1], 1'b0};
        else if (is_jal)  ex_pc_next = pc + imm_j;
        else if (taken)   ex_pc_next = pc + imm_b;
        else              ex_pc_next = pc_plus4;
    end
    assign pc_next = (state == MEM_WAIT) ? pc_plus4 : ex_pc_next;

    // Next state plus the retire strobe and the retire-gated regfile write.
    always_comb begin
        state_n = state; retire = 1'b0; rf_we = 1'b0; rf_wd = wb_val;
        case (state)
            IF_REQ:   if (imem_req_ready) state_n = IF_WAIT;
            IF_WAIT:  if (imem_resp_valid) state_n = EX;
            EX: begin
                if (is_ebreak) begin
                    retire = 1'b1; state_n = HALT;
                end else if (is_load || is_store) begin
                    state_n = MEM_REQ;
                end else begin
                    retire = 1'b1; rf_we = reg_wen; state_n = IF_REQ;
                end
            end
            MEM_REQ:  if (dmem_req_ready) state_n = MEM_WAIT;
            MEM_WAIT: if (dmem_resp_valid) begin
                          retire = 1'b1; rf_we = is_load; rf_wd = dmem_rdata; state_n = IF_REQ;
                      end
            HALT:     ;
            default:  state_n = IF_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IF_REQ;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            ir         <= '0;
            dmem_wen   <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            if (state == IF_WAIT && imem_resp_valid) ir <= imem_rdata;
            if (state == EX && (is_load || is_store)) begin
                dmem_wen   <= is_store;
                dmem_addr  <= alu_res;
                dmem_wdata <= is_store ? rs2_val : '0;
            end
            if (retire) pc <= pc_next;
        end
    end

    // x0 is never written; reads of x0 are forced to zero above.
    always_ff @(posedge clk) begin
        if (rf_we && rd != 5'd0) rf[rd] <= rf_wd;
    end

    // Valid is masked during reset so no request is presented while rst is held.
    assign imem_req_valid = (state == IF_REQ) && !rst;
    assign imem_addr      = pc;
    assign dmem_req_valid = (state == MEM_REQ);
    assign pc_out         = pc;
    assign halted         = (state == HALT);
endmodule

// File: tb/tb_core_mc.sv
module tb_core_mc;
    localparam logic [63:0] P = 64'h80000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b0, imem_resp_valid = 1'b0;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        dmem_req_valid, dmem_req_ready = 1'b0, dmem_wen, dmem_resp_valid = 1'b0;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata = '0, pc_out;
    logic        retire, halted;

    core_mc #(.XLEN(64), .RESET_PC(64'h80000000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_rdata(imem_rdata),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_wen(dmem_wen),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata),
        .pc_out(pc_out), .retire(retire), .halted(halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_ret = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && retire) n_ret <= n_ret + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the EX cycle. c0 is the first IF_REQ cycle.
    task automatic do_fetch(input logic [31:0] instr, input logic [63:0] exp_pc,
                            input int stall, input int lat, input bit noise, output int c0);
        int n;
        n = 0;
        while (!imem_req_valid && n < 50) begin @(negedge clk); n++; end
        c0 = cyc;
        check("if_vld", imem_req_valid, 1);
        check("if_addr", imem_addr, exp_pc);
        for (int i = 0; i < stall; i++) begin
            imem_resp_valid = noise; imem_rdata = 32'h00100073; dmem_resp_valid = noise;
            @(negedge clk);
            check("if_hold_vld", imem_req_valid, 1);
            check("if_hold_addr", imem_addr, exp_pc);
        end
        imem_resp_valid = 1'b0; dmem_resp_valid = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        for (int i = 1; i < lat; i++) begin
            check("if_wait_novld", imem_req_valid, 0);
            @(negedge clk);
        end
        imem_resp_valid = 1'b1; imem_rdata = instr;
        @(negedge clk);
        imem_resp_valid = 1'b0; imem_rdata = '0;
    endtask

    task automatic run_alu(input logic [31:0] instr, input logic [63:0] pc0, input logic [63:0] pc1,
                           input int stall, input int lat, input bit noise);
        int r0, c0;
        r0 = n_ret;
        do_fetch(instr, pc0, stall, lat, noise, c0);
        check("ex_retire", retire, 1);
        check("ex_lat", cyc - c0, stall + lat + 1);
        check("ex_pc_hold", pc_out, pc0);
        @(negedge clk);
        check("alu_once", n_ret - r0, 1);
        check("alu_pc", pc_out, pc1);
        check("retire_low", retire, 0);
    endtask

    task automatic run_mem(input logic [31:0] instr, input logic [63:0] pc0, input logic wen,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [63:0] rdata, input int stall);
        int r0, c0;
        r0 = n_ret;
        do_fetch(instr, pc0, 0, 1, 1'b0, c0);
        check("mem_ex_noret", retire, 0);
        @(negedge clk);
        for (int i = 0; i <= stall; i++) begin
            check("dm_vld", dmem_req_valid, 1);
            check("dm_wen", dmem_wen, wen);
            check("dm_addr", dmem_addr, addr);
            check("dm_wdata", dmem_wdata, wdata);
            dmem_req_ready = (i == stall);
            @(negedge clk);
        end
        dmem_req_ready = 1'b0;
        check("dm_wait_novld", dmem_req_valid, 0);
        check("mem_wait_noret", retire, 0);
        dmem_resp_valid = 1'b1; dmem_rdata = rdata;
        #1;
        check("mem_retire", retire, 1);
        check("mem_lat", cyc - c0, 4 + stall);
        check("mem_pc_hold", pc_out, pc0);
        @(negedge clk);
        dmem_resp_valid = 1'b0; dmem_rdata = '0;
        check("mem_pc", pc_out, pc0 + 64'd4);
        check("mem_once", n_ret - r0, 1);
    endtask

    initial begin
        int r0, c0, busy;
        repeat (3) @(negedge clk);
        check("rst_pc", pc_out, P);
        check("rst_ivld", imem_req_valid, 0);
        check("rst_dvld", dmem_req_valid, 0);
        check("rst_wen", dmem_wen, 0);
        check("rst_daddr", dmem_addr, 0);
        check("rst_dwdata", dmem_wdata, 0);
        check("rst_retire", retire, 0);
        check("rst_halted", halted, 0);
        rst = 1'b0;
        #1;
        check("rel_ivld", imem_req_valid, 1);
        check("rel_iaddr", imem_addr, P);
        @(negedge clk);

        run_alu(32'h00500093, P,         P + 64'h04, 0, 1, 1'b0); // addi x1,x0,5
        run_alu(32'h00700193, P + 64'h04, P + 64'h08, 4, 3, 1'b1); // addi x3,x0,7 with stalls/noise
        run_alu(32'h00000463, P + 64'h08, P + 64'h10, 0, 1, 1'b0); // beq x0,x0,8 taken
        run_alu(32'h00008463, P + 64'h10, P + 64'h14, 0, 1, 1'b0); // beq x1,x0,8 not taken
        run_mem(32'h00103823, P + 64'h14, 1'b1, 64'd16, 64'd5, 64'h0, 2);          // sd x1,16(x0)
        run_mem(32'h00803103, P + 64'h18, 1'b0, 64'd8, 64'd0, 64'hDEADBEEF, 0);    // ld x2,8(x0)
        run_mem(32'h00203C23, P + 64'h1c, 1'b1, 64'd24, 64'hDEADBEEF, 64'h0, 0);   // sd x2,24(x0)
        run_mem(32'h00303023, P + 64'h20, 1'b1, 64'd0, 64'd7, 64'h0, 0);           // sd x3,0(x0)
        run_alu(32'h00900013, P + 64'h24, P + 64'h28, 0, 1, 1'b0);                 // addi x0,x0,9
        run_mem(32'h00003023, P + 64'h28, 1'b1, 64'd0, 64'd0, 64'h0, 0);           // sd x0,0(x0)
        run_alu(32'h008002EF, P + 64'h2c, P + 64'h34, 0, 1, 1'b0);                 // jal x5,8
        run_mem(32'h00503023, P + 64'h34, 1'b1, 64'd0, P + 64'h30, 64'h0, 0);      // sd x5,0(x0)

        r0 = n_ret;
        do_fetch(32'h00100073, P + 64'h38, 0, 1, 1'b0, c0);                        // ebreak
        check("ebrk_retire", retire, 1);
        @(negedge clk);
        check("ebrk_halted", halted, 1);
        check("ebrk_pc", pc_out, P + 64'h38);
        check("ebrk_once", n_ret - r0, 1);
        busy = 0;
        imem_req_ready = 1'b1; dmem_req_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            imem_resp_valid = i[0]; dmem_resp_valid = ~i[0];
            @(negedge clk);
            if (imem_req_valid || dmem_req_valid || retire || !halted) busy++;
        end
        imem_req_ready = 1'b0; dmem_req_ready = 1'b0;
        imem_resp_valid = 1'b0; dmem_resp_valid = 1'b0;
        check("halt_quiet", busy, 0);
        check("halt_pc", pc_out, P + 64'h38);

        rst = 1'b1;
        #1;
        check("rst2_pc", pc_out, P);
        check("rst2_halted", halted, 0);
        check("rst2_ivld", imem_req_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel2_ivld", imem_req_valid, 1);
        check("rel2_iaddr", imem_addr, P);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
